// File: rtl/uart_pkg.sv
// Definitions shared by the UART RX and TX bus devices: register offsets, status bit layout,
// receive FSM states.
package uart_pkg;

    localparam logic [3:0] AddrData   = 4'h0;
    localparam logic [3:0] AddrStatus = 4'h8;

    localparam int unsigned StatusNotEmptyBit = 0;
    localparam int unsigned StatusFullBit     = 1;
    localparam int unsigned StatusOvrBit      = 2;
    localparam int unsigned StatusFerrBit     = 3;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_state_e;

    function automatic logic [63:0] status_word(input logic [7:0] count, input logic ferr,
                                                input logic ovr, input logic full,
                                                input logic not_empty);
        logic [63:0] w;
        w                    = '0;
        w[15:8]              = count;
        w[StatusFerrBit]     = ferr;
        w[StatusOvrBit]      = ovr;
        w[StatusFullBit]     = full;
        w[StatusNotEmptyBit] = not_empty;
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head; a push into a full FIFO is accepted only when a
// pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/uart_rx_mmio.sv
// UART 8N1 receiver: oversampling FSM feeding a byte FIFO, read through a same-cycle bus
// responder exposing DATA and STATUS registers.
module uart_rx_mmio
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rxd_i,
    input  logic        cen_i,
    input  logic        wr_i,
    input  logic [3:0]  addr_i,
    output logic [63:0] rdata_o,
    output logic        error_o
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned TickW = $clog2(CLKS_PER_BIT);
    localparam logic [TickW-1:0] HalfTick = TickW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TickW-1:0] LastTick = TickW'(CLKS_PER_BIT - 1);

    logic             rxd_meta_q, rxd_s_q;
    logic [1:0]       flush_q;
    logic             armed_q, armed_d;
    uart_state_e      state_q, state_d;
    logic [TickW-1:0] tick_q, tick_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       sh_q, sh_d;
    logic             ovr_q, ovr_d, ferr_q, ferr_d;
    logic             push, pop, set_ovr, set_ferr, status_rd;
    logic [7:0]       fifo_head;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    // The synchronizer resets to idle-high, so rxd_s only reflects the real line once two
    // edges have passed; a start bit is accepted only after a genuine high has been seen.
    assign armed_d = armed_q | (flush_q[1] & rxd_s_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
            flush_q    <= '0;
            armed_q    <= 1'b0;
            state_q    <= StIdle;
            tick_q     <= '0;
            bit_q      <= '0;
            sh_q       <= '0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            rxd_meta_q <= rxd_i;
            rxd_s_q    <= rxd_meta_q;
            flush_q    <= {flush_q[0], 1'b1};
            armed_q    <= armed_d;
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        push     = 1'b0;
        set_ovr  = 1'b0;
        set_ferr = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (armed_q && !rxd_s_q) begin
                    state_d = StStart;
                    tick_d  = '0;
                end
            end
            StStart: begin
                if (tick_q == HalfTick) begin
                    tick_d  = '0;
                    bit_d   = '0;
                    state_d = rxd_s_q ? StIdle : StData;
                end else begin
                    tick_d = tick_q + TickW'(1);
                end
            end
            StData: begin
                if (tick_q == LastTick) begin
                    tick_d = '0;
                    sh_d   = {rxd_s_q, sh_q[7:1]};
                    bit_d  = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = StStop;
                end else begin
                    tick_d = tick_q + TickW'(1);
                end
            end
            StStop: begin
                if (tick_q == LastTick) begin
                    tick_d  = '0;
                    state_d = StIdle;
                    if (!rxd_s_q)                 set_ferr = 1'b1;
                    else if (fifo_full && !pop)   set_ovr  = 1'b1;
                    else                          push     = 1'b1;
                end else begin
                    tick_d = tick_q + TickW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rdata_o   = '0;
        error_o   = 1'b0;
        pop       = 1'b0;
        status_rd = 1'b0;
        if (cen_i) begin
            if (wr_i || (addr_i != AddrData && addr_i != AddrStatus)) begin
                error_o = 1'b1;
            end else if (addr_i == AddrData) begin
                pop = !fifo_empty;
                if (!fifo_empty) rdata_o = {56'b0, fifo_head};
            end else begin
                status_rd = 1'b1;
                rdata_o   = status_word(8'(fifo_count), ferr_q, ovr_q, fifo_full, !fifo_empty);
            end
        end
    end

    // A flag raised in the same cycle as a STATUS read survives the clear.
    assign ovr_d  = set_ovr  | (ovr_q  & ~status_rd);
    assign ferr_d = set_ferr | (ferr_q & ~status_rd);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (sh_q),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Bench for uart_rx_mmio: serial frames and bus reads checked against a queue-based model
// through an expected-response scoreboard.
module tb_uart_rx_mmio;

    localparam int unsigned Cpb   = 16;
    localparam int unsigned Depth = 8;

    logic        clk, rst, rxd, cen, wr;
    logic [3:0]  addr;
    logic [63:0] rdata;
    logic        error;

    uart_rx_mmio #(
        .CLKS_PER_BIT (Cpb),
        .FIFO_DEPTH   (Depth)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .rxd_i   (rxd),
        .cen_i   (cen),
        .wr_i    (wr),
        .addr_i  (addr),
        .rdata_o (rdata),
        .error_o (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    byte unsigned model_q[$];
    bit           model_ovr, model_ferr;

    logic [63:0] exp_rdata_q[$];
    logic        exp_err_q[$];
    string       exp_name_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_status();
        int sz;
        sz = model_q.size();
        return 64'(sz) * 256 + (model_ferr ? 64'd8 : 64'd0) + (model_ovr ? 64'd4 : 64'd0)
               + (sz == Depth ? 64'd2 : 64'd0) + (sz > 0 ? 64'd1 : 64'd0);
    endfunction

    // Drives one bus cycle's inputs and records what the device must answer.
    task automatic bus_issue(input logic [3:0] a, input logic is_wr, input string name);
        logic [63:0] e;
        logic        ee;
        e  = '0;
        ee = 1'b0;
        if (is_wr || (a != 4'h0 && a != 4'h8)) begin
            ee = 1'b1;
        end else if (a == 4'h0) begin
            if (model_q.size() > 0) e = 64'(model_q.pop_front());
        end else begin
            e          = model_status();
            model_ovr  = 1'b0;
            model_ferr = 1'b0;
        end
        exp_rdata_q.push_back(e);
        exp_err_q.push_back(ee);
        exp_name_q.push_back(name);
        cen  = 1'b1;
        wr   = is_wr;
        addr = a;
    endtask

    task automatic bus_clear();
        cen  = 1'b0;
        wr   = 1'b0;
        addr = 4'h0;
    endtask

    task automatic bus_access(input logic [3:0] a, input logic is_wr, input string name);
        @(negedge clk);
        bus_issue(a, is_wr, name);
        @(negedge clk);
        bus_clear();
    endtask

    // Sends one 8N1 frame; optionally reads DATA in the cycle the stop-bit push lands, or
    // pulses reset part-way through frame bit abort_bit.
    task automatic send_frame(input byte unsigned b, input bit stop, input bit rd_in_stop,
                              input int abort_bit);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rxd = frame[i];
            if (i == abort_bit) begin
                repeat (8) @(negedge clk);
                rst = 1'b1;
                model_q.delete();
                model_ovr  = 1'b0;
                model_ferr = 1'b0;
                #2;
                check("reset_rdata", rdata, 64'd0);
                check("reset_error", 64'(error), 64'd0);
                repeat (3) @(negedge clk);
                rst = 1'b0;
                repeat (2) @(negedge clk);
                rxd = 1'b1;
                repeat (Cpb) @(negedge clk);
                return;
            end
            for (int c = 1; c < Cpb; c++) begin
                @(negedge clk);
                if (rd_in_stop && i == 9 && c == 10) bus_issue(4'h0, 1'b0, "same_cycle_pop");
                if (rd_in_stop && i == 9 && c == 11) bus_clear();
            end
        end
        @(negedge clk);
        rxd = 1'b1;
        if (stop) begin
            if (model_q.size() < Depth) model_q.push_back(b);
            else                        model_ovr = 1'b1;
        end else begin
            model_ferr = 1'b1;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic drain();
        while (model_q.size() > 0) bus_access(4'h0, 1'b0, "drain_data");
    endtask

    // Scoreboard monitor: samples mid-cycle whenever the device is selected.
    initial begin
        string       nm;
        logic [63:0] e;
        logic        ee;
        forever begin
            @(negedge clk);
            #2;
            if (cen) begin
                if (exp_rdata_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_access: rdata 0x%0h with no expectation", rdata);
                end else begin
                    e  = exp_rdata_q.pop_front();
                    ee = exp_err_q.pop_front();
                    nm = exp_name_q.pop_front();
                    check({nm, "_rdata"}, rdata, e);
                    check({nm, "_error"}, 64'(error), 64'(ee));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        byte unsigned b;
        rst  = 1'b1;
        rxd  = 1'b1;
        cen  = 1'b0;
        wr   = 1'b0;
        addr = 4'h0;
        repeat (3) @(negedge clk);
        #2;
        check("por_rdata", rdata, 64'd0);
        check("por_error", 64'(error), 64'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        bus_access(4'h8, 1'b0, "por_status");

        // Single byte
        send_frame(8'h55, 1'b1, 1'b0, -1);
        bus_access(4'h8, 1'b0, "single_status");
        bus_access(4'h0, 1'b0, "single_data");
        bus_access(4'h8, 1'b0, "single_status_after");

        // Glitch shorter than half a bit
        @(negedge clk);
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        bus_access(4'h8, 1'b0, "glitch_status");
        send_frame(8'h9E, 1'b1, 1'b0, -1);
        bus_access(4'h0, 1'b0, "after_glitch_data");

        // Framing error
        send_frame(8'hA3, 1'b0, 1'b0, -1);
        bus_access(4'h8, 1'b0, "ferr_status");
        bus_access(4'h8, 1'b0, "ferr_cleared");

        // Overrun
        for (int k = 1; k <= 9; k++) send_frame(8'(k), 1'b1, 1'b0, -1);
        bus_access(4'h8, 1'b0, "ovr_status");
        for (int k = 0; k < 8; k++) bus_access(4'h0, 1'b0, "ovr_data");
        bus_access(4'h0, 1'b0, "empty_data");
        bus_access(4'h8, 1'b0, "ovr_cleared");

        // Access errors leave FIFO and flags alone
        send_frame(8'h6B, 1'b1, 1'b0, -1);
        bus_access(4'h0, 1'b1, "wr_data");
        bus_access(4'h4, 1'b0, "rd_4");
        bus_access(4'h8, 1'b1, "wr_status");
        bus_access(4'hF, 1'b0, "rd_f");
        bus_access(4'h8, 1'b0, "err_status");
        bus_access(4'h0, 1'b0, "err_data");

        // Random traffic
        for (int k = 0; k < 10; k++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(b, ($urandom_range(0, 4) != 0), 1'b0, -1);
            if ($urandom_range(0, 1) == 1) bus_access(4'h8, 1'b0, "rand_status");
            for (int r = $urandom_range(0, 2); r > 0; r--) bus_access(4'h0, 1'b0, "rand_data");
        end
        drain();
        bus_access(4'h8, 1'b0, "rand_status_final");

        // Push and pop in the same cycle on a full FIFO
        for (int k = 0; k < 8; k++) send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0, -1);
        bus_access(4'h8, 1'b0, "full_status");
        send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b1, -1);
        bus_access(4'h8, 1'b0, "pushpop_status");
        drain();
        bus_access(4'h8, 1'b0, "pushpop_empty_status");

        // Reset during data bit 3 (frame bit 4), line low at release
        send_frame(8'h3C, 1'b1, 1'b0, -1);
        send_frame(8'h37, 1'b1, 1'b0, 4);
        bus_access(4'h8, 1'b0, "post_reset_status");
        send_frame(8'hC4, 1'b1, 1'b0, -1);
        bus_access(4'h8, 1'b0, "post_reset_rx_status");
        bus_access(4'h0, 1'b0, "post_reset_data");

        repeat (10) @(negedge clk);
        if (exp_rdata_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0",
                     exp_rdata_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
